// File: rtl/uart_tx_buffered_if.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered_if
// Byte-producer handshake into the buffered UART transmitter.
//   i_valid : producer write request
//   i_data  : character to queue (DATA_BITS wide)
//   o_ready : transmitter FIFO not full; a write is accepted when both are high
// Modports: master = byte producer, slave = uart_tx_buffered.
// -----------------------------------------------------------------------------
interface uart_tx_buffered_if #(
   parameter int DATA_BITS = 8
);
   logic                 i_valid;
   logic [DATA_BITS-1:0] i_data;
   logic                 o_ready;

   modport master (
      output i_valid,
      output i_data,
      input  o_ready
   );

   modport slave (
      input  i_valid,
      input  i_data,
      output o_ready
   );
endinterface

// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
// UART transmitter with a TX FIFO, configurable frame format and a runtime
// baud divisor. Characters are queued through the bus interface and sent
// LSB first as: start, DATA_BITS data, optional parity, STOP_BITS stop bits.
// Ports:
//   i_clk        : system clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_baud_div   : clock cycles per bit (values below 2 act as 2), sampled at pop
//   bus          : i_valid / i_data / o_ready write handshake (slave side)
//   o_fifo_count : entries currently queued
//   o_overflow   : one-cycle pulse for a write attempted while full
//   o_busy       : high from START through DONE
//   o_done       : one-cycle pulse in DONE
//   o_dout       : serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_buffered #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [DIV_WIDTH-1:0]          i_baud_div,
   uart_tx_buffered_if.slave             bus,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
   output logic                          o_overflow,
   output logic                          o_busy,
   output logic                          o_done,
   output logic                          o_dout
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [5:0] {
      S_IDLE   = 6'b000001,
      S_START  = 6'b000010,
      S_DATA   = 6'b000100,
      S_PARITY = 6'b001000,
      S_STOP   = 6'b010000,
      S_DONE   = 6'b100000
   } state_t;

   // FIFO storage and bookkeeping
   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q;
   logic [AW-1:0]        rd_ptr_q;
   logic [CW-1:0]        count_q;
   logic                 overflow_q;
   logic                 ready;
   logic                 push;
   logic                 pop;

   // Transmit engine
   state_t               state_q;
   logic [DIV_WIDTH-1:0] div_q;
   logic [DIV_WIDTH-1:0] tick_q;
   logic [3:0]           bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 dout_q;
   logic                 busy_q;
   logic                 done_q;

   logic [DIV_WIDTH-1:0] div_clamped;
   logic                 tick_wrap;
   logic                 par_bit;

   // Ready comes from the registered count only, so a write while full is
   // dropped even when a pop happens in the same cycle.
   assign ready       = (count_q != CW'(FIFO_DEPTH));
   assign push        = bus.i_valid && ready;
   assign pop         = (state_q == S_IDLE) && (count_q != '0);
   assign bus.o_ready = ready;

   assign div_clamped = (i_baud_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : i_baud_div;
   assign tick_wrap   = (tick_q == div_q - DIV_WIDTH'(1));
   assign par_bit     = (PARITY == 1) ? ^data_q : ~^data_q;

   // ---------------------------------------------------------------- FIFO --
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.i_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= bus.i_valid && !ready;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // ------------------------------------------------------------- TX FSM --
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         dout_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               dout_q <= 1'b1;
               if (pop) begin
                  shift_q <= mem_q[rd_ptr_q];
                  data_q  <= mem_q[rd_ptr_q];
                  div_q   <= div_clamped;
                  tick_q  <= '0;
                  bit_q   <= '0;
                  dout_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (tick_wrap) begin
                  tick_q  <= '0;
                  dout_q  <= shift_q[0];
                  state_q <= S_DATA;
               end else begin
                  tick_q <= tick_q + DIV_WIDTH'(1);
               end
            end
            S_DATA: begin
               if (tick_wrap) begin
                  tick_q <= '0;
                  if (bit_q == 4'(DATA_BITS - 1)) begin
                     bit_q <= '0;
                     if (PARITY != 0) begin
                        dout_q  <= par_bit;
                        state_q <= S_PARITY;
                     end else begin
                        dout_q  <= 1'b1;
                        state_q <= S_STOP;
                     end
                  end else begin
                     // Line is registered, so present the next bit as we shift.
                     bit_q   <= bit_q + 4'd1;
                     shift_q <= shift_q >> 1;
                     dout_q  <= shift_q[1];
                  end
               end else begin
                  tick_q <= tick_q + DIV_WIDTH'(1);
               end
            end
            S_PARITY: begin
               if (tick_wrap) begin
                  tick_q  <= '0;
                  dout_q  <= 1'b1;
                  state_q <= S_STOP;
               end else begin
                  tick_q <= tick_q + DIV_WIDTH'(1);
               end
            end
            S_STOP: begin
               if (tick_wrap) begin
                  tick_q <= '0;
                  if (bit_q == 4'(STOP_BITS - 1)) begin
                     bit_q   <= '0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     bit_q <= bit_q + 4'd1;
                  end
               end else begin
                  tick_q <= tick_q + DIV_WIDTH'(1);
               end
            end
            S_DONE: begin
               dout_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               dout_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign o_fifo_count = count_q;
   assign o_overflow   = overflow_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_dout       = dout_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buffered
// Four transmitter instances share clock and reset:
//   A: 8N1, B: 7E1, C: 7O1, D: 8N2 (all FIFO_DEPTH 8, DIV_WIDTH 16).
// Single frames are table-driven; back-to-back, FIFO overflow, mid-frame baud
// change and mid-frame reset are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_uart_tx_buffered;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;

   logic [3:0] valid_r;
   logic [7:0] data_r [4];
   logic [15:0] div_r [4];

   logic [3:0] dout_w, busy_w, done_w, ovf_w, ready_w;
   logic [3:0] cnt_w [4];

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   uart_tx_buffered_if #(.DATA_BITS(8)) if_a ();
   uart_tx_buffered_if #(.DATA_BITS(7)) if_b ();
   uart_tx_buffered_if #(.DATA_BITS(7)) if_c ();
   uart_tx_buffered_if #(.DATA_BITS(8)) if_d ();

   assign if_a.i_valid = valid_r[0];
   assign if_a.i_data  = data_r[0];
   assign ready_w[0]   = if_a.o_ready;
   assign if_b.i_valid = valid_r[1];
   assign if_b.i_data  = data_r[1][6:0];
   assign ready_w[1]   = if_b.o_ready;
   assign if_c.i_valid = valid_r[2];
   assign if_c.i_data  = data_r[2][6:0];
   assign ready_w[2]   = if_c.o_ready;
   assign if_d.i_valid = valid_r[3];
   assign if_d.i_data  = data_r[3];
   assign ready_w[3]   = if_d.o_ready;

   uart_tx_buffered #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(8), .DIV_WIDTH(16)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_baud_div(div_r[0]), .bus(if_a),
      .o_fifo_count(cnt_w[0]), .o_overflow(ovf_w[0]), .o_busy(busy_w[0]),
      .o_done(done_w[0]), .o_dout(dout_w[0]));

   uart_tx_buffered #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(8), .DIV_WIDTH(16)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_baud_div(div_r[1]), .bus(if_b),
      .o_fifo_count(cnt_w[1]), .o_overflow(ovf_w[1]), .o_busy(busy_w[1]),
      .o_done(done_w[1]), .o_dout(dout_w[1]));

   uart_tx_buffered #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(8), .DIV_WIDTH(16)) u_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_baud_div(div_r[2]), .bus(if_c),
      .o_fifo_count(cnt_w[2]), .o_overflow(ovf_w[2]), .o_busy(busy_w[2]),
      .o_done(done_w[2]), .o_dout(dout_w[2]));

   uart_tx_buffered #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(8), .DIV_WIDTH(16)) u_d (
      .i_clk(clk), .i_rst_n(rst_n), .i_baud_div(div_r[3]), .bus(if_d),
      .o_fifo_count(cnt_w[3]), .o_overflow(ovf_w[3]), .o_busy(busy_w[3]),
      .o_done(done_w[3]), .o_dout(dout_w[3]));

   // One single-frame vector: which DUT, what to write, divisor to drive,
   // resulting cycles per bit, and the expected line bits in time order
   // (start, data LSB first, parity, stop).
   typedef struct {
      int          dut;
      logic [7:0]  data;
      logic [15:0] div_in;
      int unsigned bitlen;
      string       frame;
   } vec_t;

   function automatic vec_t mk(input int d, input logic [7:0] c, input logic [15:0] dv,
                               input int unsigned bl, input string f);
      vec_t v;
      v.dut = d; v.data = c; v.div_in = dv; v.bitlen = bl; v.frame = f;
      return v;
   endfunction

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Write one character at the next falling edge; the following cycle is the
   // IDLE pop cycle, where the line must still be high.
   task automatic write_start(input int idx, input logic [7:0] d);
      @(negedge clk);
      valid_r[idx] = 1'b1;
      data_r[idx]  = d;
      @(negedge clk);
      valid_r[idx] = 1'b0;
      chk("pop_cycle_line", dout_w[idx], 1);
      chk("pop_cycle_count", cnt_w[idx], 1);
   endtask

   task automatic check_line(input int idx, input string fr, input int unsigned bl);
      int unsigned bc = 0;
      for (int i = 0; i < fr.len(); i++) begin
         for (int unsigned j = 0; j < bl; j++) begin
            @(negedge clk);
            chk($sformatf("line_bit%0d", i), dout_w[idx], (fr[i] == 8'h31) ? 1 : 0);
            bc += busy_w[idx];
         end
      end
      chk("busy_len", bc, fr.len() * bl);
   endtask

   task automatic check_done(input int idx);
      @(negedge clk);
      chk("done_pulse", done_w[idx], 1);
      chk("done_busy", busy_w[idx], 1);
      chk("done_line", dout_w[idx], 1);
   endtask

   task automatic check_gap(input int idx);
      @(negedge clk);
      chk("idle_done", done_w[idx], 0);
      chk("idle_busy", busy_w[idx], 0);
      chk("idle_line", dout_w[idx], 1);
   endtask

   // Mid-bit sampling receiver for 8-bit frames; tolerates starting partway
   // into a start bit.
   task automatic rx_byte(input int idx, input int unsigned bl, output logic [7:0] b);
      int unsigned w = 0;
      b = '0;
      while (dout_w[idx] !== 1'b0 && w < 5000) begin
         @(negedge clk);
         w++;
      end
      chk("rx_start_seen", (w < 5000) ? 1 : 0, 1);
      repeat (bl / 2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         repeat (bl) @(negedge clk);
         b[k] = dout_w[idx];
      end
      repeat (bl) @(negedge clk);
      chk("rx_stop", dout_w[idx], 1);
   endtask

   vec_t vecs[8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0]  got;
      int unsigned act;

      vecs[0] = mk(0, 8'hA5, 16'd4, 4, "0101001011");
      vecs[1] = mk(1, 8'h41, 16'd3, 3, "0100000101");
      vecs[2] = mk(2, 8'h41, 16'd3, 3, "0100000111");
      vecs[3] = mk(0, 8'h00, 16'd0, 2, "0000000001");
      vecs[4] = mk(0, 8'h3C, 16'd2, 2, "0001111001");
      vecs[5] = mk(1, 8'h7F, 16'd2, 2, "0111111111");
      vecs[6] = mk(2, 8'h2A, 16'd1, 2, "0010101001");
      vecs[7] = mk(3, 8'hA5, 16'd3, 3, "01010010111");

      valid_r = '0;
      for (int i = 0; i < 4; i++) begin
         data_r[i] = '0;
         div_r[i]  = 16'd4;
      end

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_dout", dout_w[0], 1);
      chk("rst_busy", busy_w[0], 0);
      chk("rst_done", done_w[0], 0);
      chk("rst_overflow", ovf_w[0], 0);
      chk("rst_ready", ready_w[0], 1);
      chk("rst_count", cnt_w[0], 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single frames
      foreach (vecs[v]) begin
         div_r[vecs[v].dut] = vecs[v].div_in;
         write_start(vecs[v].dut, vecs[v].data);
         check_line(vecs[v].dut, vecs[v].frame, vecs[v].bitlen);
         check_done(vecs[v].dut);
         check_gap(vecs[v].dut);
      end

      // 8N2, div 5, 0x00 then 0xFF back-to-back: two high cycles between frames
      div_r[3] = 16'd5;
      @(negedge clk);
      valid_r[3] = 1'b1;
      data_r[3]  = 8'h00;
      @(negedge clk);
      data_r[3]  = 8'hFF;
      chk("b2b_pop_line", dout_w[3], 1);
      fork
         check_line(3, "00000000011", 5);
         begin
            @(negedge clk);
            valid_r[3] = 1'b0;
         end
      join
      check_done(3);
      check_gap(3);
      check_line(3, "01111111111", 5);
      check_done(3);
      check_gap(3);

      // Divisor change mid-frame: current frame keeps 4, next frame uses 8
      div_r[0] = 16'd4;
      write_start(0, 8'h5A);
      fork
         check_line(0, "0010110101", 4);
         begin
            @(negedge clk);
            div_r[0]   = 16'd8;
            valid_r[0] = 1'b1;
            data_r[0]  = 8'hC3;
            @(negedge clk);
            valid_r[0] = 1'b0;
         end
      join
      check_done(0);
      check_gap(0);
      check_line(0, "0110000111", 8);
      check_done(0);
      check_gap(0);

      // FIFO fill at div 100: writes 0..8 accepted, write 9 dropped
      div_r[0] = 16'd100;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 9) begin
            chk("full_ready", ready_w[0], 0);
            chk("full_count", cnt_w[0], 8);
         end else begin
            chk($sformatf("ready_before_write%0d", i), ready_w[0], 1);
         end
         valid_r[0] = 1'b1;
         data_r[0]  = 8'(i);
      end
      @(negedge clk);
      valid_r[0] = 1'b0;
      chk("overflow_pulse", ovf_w[0], 1);
      chk("count_after_drop", cnt_w[0], 8);
      @(negedge clk);
      chk("overflow_clear", ovf_w[0], 0);
      for (int i = 0; i < 9; i++) begin
         rx_byte(0, 100, got);
         chk($sformatf("rx_char%0d", i), got, i);
      end
      repeat (60) @(negedge clk);
      act = 0;
      repeat (300) begin
         @(negedge clk);
         if (dout_w[0] == 1'b0) act++;
      end
      chk("no_dropped_char_sent", act, 0);
      chk("drained_count", cnt_w[0], 0);
      chk("drained_busy", busy_w[0], 0);

      // Reset mid-DATA with three characters queued
      div_r[0] = 16'd4;
      @(negedge clk); valid_r[0] = 1'b1; data_r[0] = 8'h10;
      @(negedge clk); data_r[0] = 8'h22;
      @(negedge clk); data_r[0] = 8'h33;
      @(negedge clk); data_r[0] = 8'h44;
      @(negedge clk); valid_r[0] = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_reset_line", dout_w[0], 0);
      chk("pre_reset_count", cnt_w[0], 3);
      chk("pre_reset_busy", busy_w[0], 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_dout", dout_w[0], 1);
      chk("async_rst_busy", busy_w[0], 0);
      chk("async_rst_count", cnt_w[0], 0);
      chk("async_rst_ready", ready_w[0], 1);
      @(negedge clk);
      rst_n = 1'b1;
      act = 0;
      repeat (80) begin
         @(negedge clk);
         if (dout_w[0] == 1'b0 || busy_w[0] == 1'b1 || done_w[0] == 1'b1) act++;
      end
      chk("post_reset_quiet", act, 0);
      chk("post_reset_count", cnt_w[0], 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
